// File: rtl/nonogram_pkg.sv
// Shared types and defaults for the nonogram board parser.
package nonogram_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_N    = 2'd1,
    GET_DATA = 2'd2,
    GET_STOP = 2'd3
  } state_t;

  localparam logic [7:0] STOP_BYTE    = 8'hFF;
  localparam int         DEF_MAX_ROWS = 11;
  localparam int         DEF_MAX_COLS = 11;
endpackage

// File: rtl/byte_timer.sv
// Inter-byte idle counter: counts clocks while run is high, restarts on clear,
// and flags expired on the TIMEOUT_CYCLES-th consecutive idle clock.
module byte_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] count;

  assign expired = run && !clear && (count == TW'(TIMEOUT_CYCLES - 1));

  // Idle-clock counter; held at zero outside a frame and on every byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          count <= '0;
    else if (!run || clear || expired) count <= '0;
    else                              count <= count + 1'b1;
  end
endmodule

// File: rtl/board_parser.sv
// Board frame parser: m, n, ceil(m*n/8) data bytes, stop byte 0xFF.
// Optional inter-byte timeout enabled by defining PARSER_TIMEOUT_EN.
module board_parser
  import nonogram_pkg::*;
#(
  parameter int MAX_ROWS       = DEF_MAX_ROWS,
  parameter int MAX_COLS       = DEF_MAX_COLS,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  input  logic [7:0]                       byte_in,
  output logic [$clog2(MAX_ROWS+1)-1:0]    m,
  output logic [$clog2(MAX_COLS+1)-1:0]    n,
  output logic [MAX_ROWS*MAX_COLS-1:0]     solution,
  output logic                             valid_out,
  output logic                             busy,
  output logic                             error
);
  localparam int MW    = $clog2(MAX_ROWS + 1);
  localparam int NW    = $clog2(MAX_COLS + 1);
  localparam int CELLS = MAX_ROWS * MAX_COLS;
  // Wide enough for m*n+7 and for the bit offset of the last data byte.
  localparam int IW    = $clog2(CELLS + 8) + 1;

  state_t                state;
  logic [IW-1:0]         prod;
  logic [IW-1:0]         dbytes;
  logic [IW-1:0]         cnt;
  logic [IW-1:0]         base;
  logic [IW-1:0]         prod_n;
  logic [CELLS-1:0]      sol_wr;
  logic                  m_bad;
  logic                  n_bad;
  logic                  expired;

  assign busy   = (state != IDLE);
  assign base   = {cnt[IW-4:0], 3'b000};
  assign prod_n = IW'(m) * IW'(byte_in[NW-1:0]);
  assign m_bad  = (byte_in == 8'd0) || (int'(byte_in) > MAX_ROWS);
  assign n_bad  = (byte_in == 8'd0) || (int'(byte_in) > MAX_COLS);

`ifdef PARSER_TIMEOUT_EN
  byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (busy),
    .clear   (valid_in),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Merge the current data byte into the board; bits past m*n are dropped.
  always_comb begin
    sol_wr = solution;
    for (int c = 0; c < CELLS; c++) begin
      if (IW'(c) >= base && IW'(c) < base + IW'(8) && IW'(c) < prod)
        sol_wr[c] = byte_in[3'(IW'(c) - base)];
    end
  end

  // Frame FSM; valid_out/error are registered one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m         <= '0;
      n         <= '0;
      solution  <= '0;
      prod      <= '0;
      dbytes    <= '0;
      cnt       <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      error     <= 1'b0;
      if (expired) begin
        state <= IDLE;
        error <= 1'b1;
      end else if (valid_in) begin
        case (state)
          IDLE: begin
            // A bad m never starts a frame, so the previous board is kept.
            if (m_bad) error <= 1'b1;
            else begin
              m        <= byte_in[MW-1:0];
              solution <= '0;
              state    <= GET_N;
            end
          end
          GET_N: begin
            if (n_bad) begin
              error <= 1'b1;
              state <= IDLE;
            end else begin
              n      <= byte_in[NW-1:0];
              prod   <= prod_n;
              dbytes <= (prod_n + IW'(7)) >> 3;
              cnt    <= '0;
              state  <= GET_DATA;
            end
          end
          GET_DATA: begin
            solution <= sol_wr;
            cnt      <= cnt + 1'b1;
            if (cnt == dbytes - 1'b1) state <= GET_STOP;
          end
          default: begin
            state <= IDLE;
            if (byte_in == STOP_BYTE) valid_out <= 1'b1;
            else                      error     <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_board_parser.sv
// Scoreboard bench for board_parser (3x3 board, timeout 50 when enabled).
module tb_board_parser;
  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [7:0] byte_in;
  logic [1:0] m;
  logic [1:0] n;
  logic [8:0] solution;
  logic       valid_out;
  logic       busy;
  logic       error;

  board_parser #(.MAX_ROWS(3), .MAX_COLS(3), .TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .byte_in   (byte_in),
    .m         (m),
    .n         (n),
    .solution  (solution),
    .valid_out (valid_out),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int em;
    int en;
    int esol;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    valid_in = 1'b1;
    byte_in  = b;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic push_ok(input int em, input int en, input int esol);
    exp_t e;
    e.is_err = 1'b0; e.em = em; e.en = en; e.esol = esol;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.em = 0; e.en = 0; e.esol = 0;
    q.push_back(e);
  endtask

  // Monitor: every output pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && (valid_out || error)) begin
      exp_t e;
      chk("pulse_exclusive", int'(valid_out && error), 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_err", int'(error), int'(e.is_err));
        if (!e.is_err && valid_out) begin
          chk("m", int'(m), e.em);
          chk("n", int'(n), e.en);
          chk("solution", int'(solution), e.esol);
          chk("busy_at_valid", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    byte_in  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m", int'(m), 0);
    chk("rst_n", int'(n), 0);
    chk("rst_sol", int'(solution), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_err", int'(error), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 3x3 frame.
    push_ok(3, 3, 9'b101110111);
    send(8'h03, 0);
    chk("busy_after_m", int'(busy), 1);
    send(8'h03, 0);
    send(8'h77, 0);
    send(8'h01, 0);
    send(8'hFF, 0);
    chk("busy_after_stop", int'(busy), 0);
    repeat (4) begin @(posedge clk); #1; end
    chk("hold_m", int'(m), 3);
    chk("hold_sol", int'(solution), 9'b101110111);

    // Bad stop byte.
    push_err();
    send(8'h03, 0); send(8'h03, 0); send(8'h77, 0); send(8'h01, 0); send(8'h00, 0);
    chk("busy_after_badstop", int'(busy), 0);
    repeat (2) begin @(posedge clk); #1; end

    // m out of range, then a good frame right after.
    push_err();
    send(8'h04, 0);
    chk("busy_after_bad_m", int'(busy), 0);
    push_ok(3, 3, 9'b101110111);
    send(8'h03, 0); send(8'h03, 0); send(8'h77, 0); send(8'h01, 0); send(8'hFF, 1);

    // n == 0 and n > MAX_COLS, then m == 0.
    push_err();
    send(8'h02, 0); send(8'h00, 1);
    push_err();
    send(8'h02, 0); send(8'h04, 1);
    chk("busy_after_bad_n", int'(busy), 0);
    push_err();
    send(8'h00, 1);

    // Reset mid-frame.
    send(8'h03, 0); send(8'h03, 0); send(8'h77, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_m", int'(m), 0);
    chk("mid_rst_n", int'(n), 0);
    chk("mid_rst_sol", int'(solution), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    push_ok(2, 2, 9'b000001111);
    send(8'h02, 0); send(8'h02, 0); send(8'h0F, 0); send(8'hFF, 1);

    // Back-to-back frames, a byte every other cycle.
    push_ok(1, 3, 9'b000000101);
    send(8'h01, 1); send(8'h03, 1); send(8'h05, 1); send(8'hFF, 1);
    push_ok(3, 2, 9'b000101010);
    send(8'h03, 1); send(8'h02, 1); send(8'h2A, 1); send(8'hFF, 1);

`ifdef PARSER_TIMEOUT_EN
    // Stalled frame: timeout fires after 50 idle clocks.
    push_err();
    send(8'h03, 0); send(8'h03, 0);
    repeat (45) begin @(posedge clk); #1; end
    chk("busy_before_timeout", int'(busy), 1);
    repeat (15) begin @(posedge clk); #1; end
    chk("busy_after_timeout", int'(busy), 0);
`else
    // Stalled frame waits indefinitely.
    send(8'h03, 0); send(8'h03, 0);
    repeat (60) begin @(posedge clk); #1; end
    chk("busy_stalled", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    repeat (5) begin @(posedge clk); #1; end
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/board_parser.md
BOARD_PARSER -- requirements
Module: board_parser

Interface
REQ-001 SHALL have parameter MAX_ROWS, default 11, meaning the maximum accepted row count m.
REQ-002 SHALL have parameter MAX_COLS, default 11, meaning the maximum accepted column count n.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the allowed idle clocks between bytes within a frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port valid_in, input, 1 bit: byte_in is valid this cycle (one-cycle pulse from the UART receiver).
REQ-007 SHALL have port byte_in, input, 8 bits: received byte.
REQ-008 SHALL have port m, output, $clog2(MAX_ROWS+1) bits: the parsed row count.
REQ-009 SHALL have port n, output, $clog2(MAX_COLS+1) bits: the parsed column count.
REQ-010 SHALL have port solution, output, MAX_ROWS*MAX_COLS bits: cell (r,c) is at bit r*n+c.
REQ-011 SHALL have port valid_out, output, 1 bit: one-cycle pulse marking a complete, well-formed frame.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port error, output, 1 bit: one-cycle pulse marking a malformed frame.

Function
REQ-014 Frame format SHALL be: byte m, byte n, then D = ceil(m*n/8) data bytes, then stop byte 0xFF.
REQ-015 Data byte k SHALL carry solution bits 8k..8k+7, with byte bit 0 mapping to the lowest index; bits at index >= m*n SHALL be discarded.
REQ-016 The FSM SHALL have states IDLE, GET_N, GET_DATA, GET_STOP.
REQ-017 IDLE: on valid_in, SHALL latch m, clear solution to zero, assert busy and go to GET_N.
REQ-018 GET_N: on valid_in, SHALL latch n, compute D, clear the byte counter and go to GET_DATA.
REQ-019 GET_DATA: on each valid_in, SHALL write 8 bits at offset 8*count and increment count; after the D-th byte it SHALL go to GET_STOP.
REQ-020 GET_STOP: on byte 0xFF, SHALL pulse valid_out the following cycle and return to IDLE.
REQ-021 GET_STOP: on any other byte, SHALL pulse error and return to IDLE.
REQ-022 When m==0, m>MAX_ROWS, n==0 or n>MAX_COLS, the block SHALL pulse error on the cycle after the offending byte, return to IDLE and ignore bytes until the next frame.
REQ-023 busy SHALL be high from the cycle after the m byte is accepted until the cycle the FSM re-enters IDLE.
REQ-024 m, n and solution SHALL be registered and held stable from valid_out until the next m byte is accepted.
REQ-025 valid_out and error SHALL never be asserted in the same cycle.
REQ-026 The m*n product and the offset computations SHALL be sized for MAX_ROWS*MAX_COLS without overflow.

Reset
REQ-027 Asserting rst at any time, including mid-frame, SHALL force state IDLE, m=0, n=0, solution=0, valid_out=0, busy=0, error=0 and byte counter=0.
REQ-028 The first byte after rst deasserts SHALL be treated as m.

Configuration
REQ-029 With PARSER_TIMEOUT_EN defined, a counter SHALL run while busy and clear on every valid_in.
REQ-030 With PARSER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL pulse error and return the FSM to IDLE.
REQ-031 Without PARSER_TIMEOUT_EN, no timeout logic SHALL exist and a stalled frame SHALL wait indefinitely.

Structure
REQ-032 A shared package nonogram_pkg SHALL hold the FSM state enum, STOP_BYTE = 8'hFF, and the default MAX_ROWS and MAX_COLS.
REQ-033 Sub-module byte_timer (the inter-byte timeout counter) SHALL be instantiated only under PARSER_TIMEOUT_EN.

Verification
REQ-034 MAX 3x3, bytes 03,03,77,01,FF -> valid_out pulses once; m=3, n=3, solution=9'b101110111; busy falls.
REQ-035 Bytes 03,03,77,01,00 -> error pulses once; valid_out stays 0; FSM returns to IDLE.
REQ-036 Byte 04 as m with MAX_ROWS=3 -> error on the next cycle; the following 03,03,77,01,FF frame parses correctly.
REQ-037 rst pulsed after 03,03,77 -> all outputs 0; a fresh 02,02,0F,FF frame yields solution=9'b000001111 and m=n=2.
REQ-038 With PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=50, bytes 03,03 then 60 idle clocks -> error pulse at 50 clocks; busy falls.
REQ-039 Back-to-back frames with valid_in every other cycle -> two valid_out pulses with correct solutions in each.
